aes_core_scheduler: RTL and testbench
=====================================

# aes_core_scheduler

Round-robin scheduler that shares one single-block AES-128 encryption core among NUM_REQ independent requesters. Each requester presents a plaintext/key pair on a valid/ready request channel and receives its ciphertext on a valid/ready response channel. The scheduler sequences the core (start pulse, completion wait, result capture) with exactly one block in flight at a time, and guards against a hung core with a completion watchdog.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8
- TIMEOUT, 32: max cycles in WAIT before the block is aborted, must be >= 12

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  request valid, one bit per requester
- req_ready  out  NUM_REQ  request accept, at most one bit high
- req_plaintext  in  NUM_REQ*128  plaintext, requester i at [128*i +: 128]
- req_key  in  NUM_REQ*128  cipher key, same packing
- resp_valid  out  NUM_REQ  response valid, at most one bit high
- resp_ready  in  NUM_REQ  response accept
- resp_ciphertext  out  128  result, shared by all requesters, qualified by resp_valid
- resp_err  out  1  result aborted by watchdog, qualified by resp_valid
- core_start  out  1  one-cycle start pulse to the core
- core_plaintext  out  128  plaintext to the core
- core_key  out  128  key to the core
- core_ciphertext  in  128  core result
- core_done  in  1  core completion; high from completion until the next start
- busy  out  1  high in every state except IDLE
- grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: the winner is chosen combinationally from req_valid. Priority starts at (last_grant+1) mod NUM_REQ and wraps. Only the winner's req_ready is high.
  - On handshake: capture the winner's plaintext and key into core_plaintext/core_key, set grant_id and last_grant, then go to ISSUE.
  - With no req_valid, stay in IDLE.
- ISSUE: core_start=1 for exactly one cycle, then go to WAIT. Clear the watchdog counter.
- WAIT: core_start=0 and the counter increments each cycle.
  - core_done=1: capture core_ciphertext into resp_ciphertext, resp_err=0, go to RESP.
  - counter==TIMEOUT with core_done=0: resp_ciphertext=0, resp_err=1, go to RESP.
  - core_done and timeout in the same cycle: done wins and resp_err=0.
- RESP: resp_valid[grant_id]=1 and all other bits are 0. When resp_ready[grant_id]=1, go to IDLE. resp_ready on non-granted bits is ignored.
- core_plaintext and core_key stay stable from capture until the next IDLE handshake.
- req_valid falling without a handshake is legal and has no effect.
- Reset, any state: state=IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority). All outputs are 0, including req_ready, resp_valid, resp_ciphertext, resp_err, core_start, core_plaintext, core_key, busy and grant_id. The core shares rst_n, so an in-flight block is discarded and no response is issued.
- Watchdog counter width is $clog2(TIMEOUT+1) and it saturates.

## Timing
- Request handshake at edge E0 → ISSUE during E0..E1 → core samples start at E1 → core_done high after E11 → capture at E12.
- resp_valid is high from E12: 12 cycles from request acceptance to response for a nominal core.
- Back-to-back: a response accepted at edge R allows the next request to be accepted at edge R+1 at the earliest. Service interval is therefore 14 cycles minimum.
- req_ready is never high outside IDLE.
- No combinational path from resp_ready to req_ready; they are high in different states.

## Test plan
- FIPS-197 vector on requester 2: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff → resp_valid[2] at 12 cycles after accept, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, resp_err=0.
- All 4 requesters hold req_valid with distinct vectors → grant order 0,1,2,3,0; each response matches its own vector; at most one req_ready/resp_valid bit high at any time.
- Backpressure: hold resp_ready[1]=0 for 20 cycles → resp_valid[1] and resp_ciphertext stable, busy=1, no new req_ready; release → return to IDLE next edge.
- Stub core that never asserts core_done, TIMEOUT=32 → resp_valid with resp_err=1, ciphertext 0, 32 cycles after WAIT entry; next request serviced normally with a real core.
- Assert rst_n low in WAIT (cycle 5) → all outputs 0 immediately; after release, requester 0 wins over simultaneous requester 3; no stale response appears.

Source files
------------

// File: rtl/aes_core_scheduler.sv
// Round-robin scheduler sharing one AES-128 block core among NUM_REQ requesters.
// One block in flight; a watchdog aborts blocks the core never completes.
module aes_core_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 32,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_plaintext,
  input  logic [NUM_REQ*128-1:0] req_key,
  output logic [NUM_REQ-1:0]     resp_valid,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic [127:0]           resp_ciphertext,
  output logic                   resp_err,
  output logic                   core_start,
  output logic [127:0]           core_plaintext,
  output logic [127:0]           core_key,
  input  logic [127:0]           core_ciphertext,
  input  logic                   core_done,
  output logic                   busy,
  output logic [IW-1:0]          grant_id
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   win;
  logic [IW-1:0]   idx;
  logic            win_ok;
  logic [CW-1:0]   wd_cnt;
  logic [CW-1:0]   wd_inc;
  logic            timeout;

  // Search starts one past the last grant and wraps.
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((int'(last_grant) + 1 + k) % NUM_REQ);
      if (!win_ok && req_valid[idx]) begin
        win_ok = 1'b1;
        win    = idx;
      end
    end
  end

  assign wd_inc  = (wd_cnt == CW'(TIMEOUT)) ? wd_cnt : wd_cnt + 1'b1;
  assign timeout = (wd_inc == CW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (win_ok) state_n = ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    if (core_done || timeout) state_n = RESP;
      RESP:    if (resp_ready[grant_id]) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant      <= IW'(NUM_REQ - 1);
      grant_id        <= '0;
      core_plaintext  <= '0;
      core_key        <= '0;
      resp_ciphertext <= '0;
      resp_err        <= 1'b0;
      wd_cnt          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_ok) begin
            core_plaintext <= req_plaintext[int'(win)*128 +: 128];
            core_key       <= req_key[int'(win)*128 +: 128];
            grant_id       <= win;
            last_grant     <= win;
          end
        end
        ISSUE: wd_cnt <= '0;
        WAIT: begin
          wd_cnt <= wd_inc;
          // Completion takes precedence over a coincident timeout.
          if (core_done) begin
            resp_ciphertext <= core_ciphertext;
            resp_err        <= 1'b0;
          end else if (timeout) begin
            resp_ciphertext <= '0;
            resp_err        <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (rst_n && state == IDLE && win_ok) req_ready[win] = 1'b1;
    if (state == RESP) resp_valid[grant_id] = 1'b1;
  end

  assign core_start = (state == ISSUE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_aes_core_scheduler.sv
// Scoreboard bench for aes_core_scheduler with a table-driven stand-in core.
// Known AES-128 vectors come from a table; other inputs return plaintext^key.
module tb_aes_core_scheduler;
  localparam int N  = 4;
  localparam int TO = 32;

  localparam logic [127:0] K_F = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_F = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_F = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_Z = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] P_X = 128'h11111111111111111111111111111111;
  localparam logic [127:0] K_X = 128'h22222222222222222222222222222222;
  localparam logic [127:0] C_X = 128'h33333333333333333333333333333333;
  localparam logic [127:0] P_Y = 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;
  localparam logic [127:0] K_Y = 128'hf0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0;
  localparam logic [127:0] C_Y = 128'hffffffffffffffffffffffffffffffff;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*128-1:0]   req_plaintext;
  logic [N*128-1:0]   req_key;
  logic [N-1:0]       resp_valid;
  logic [N-1:0]       resp_ready;
  logic [127:0]       resp_ciphertext;
  logic               resp_err;
  logic               core_start;
  logic [127:0]       core_plaintext;
  logic [127:0]       core_key;
  logic [127:0]       core_ciphertext;
  logic               core_done;
  logic               busy;
  logic [1:0]         grant_id;

  always #5 clk = ~clk;

  aes_core_scheduler #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_plaintext(req_plaintext), .req_key(req_key),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_ciphertext(resp_ciphertext), .resp_err(resp_err),
    .core_start(core_start), .core_plaintext(core_plaintext),
    .core_key(core_key), .core_ciphertext(core_ciphertext),
    .core_done(core_done), .busy(busy), .grant_id(grant_id)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] aes_ref(logic [127:0] p, logic [127:0] k);
    if (p == P_F && k == K_F) return C_F;
    if (p == P_B && k == K_B) return C_B;
    if (p == '0 && k == '0)   return C_Z;
    return p ^ k;
  endfunction

  // Stand-in core: start sampled at E1, done raised at E11.
  logic         hang = 1'b0;
  logic [3:0]   ccnt;
  logic [127:0] chold;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccnt <= '0;
      core_done <= 1'b0;
      chold <= '0;
    end else if (core_start) begin
      ccnt <= 4'd1;
      core_done <= 1'b0;
      chold <= aes_ref(core_plaintext, core_key);
    end else if (ccnt == 4'd10) begin
      ccnt <= '0;
      if (!hang) core_done <= 1'b1;
    end else if (ccnt != 0) begin
      ccnt <= ccnt + 1'b1;
    end
  end
  assign core_ciphertext = hang ? 128'hdeadbeefdeadbeefdeadbeefdeadbeef : chold;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int           id;
    logic [127:0] ct;
    logic         err;
  } exp_t;
  exp_t exp_q[$];
  exp_t me;
  int   mid;

  task automatic expect_resp(int id, logic [127:0] ct, logic err);
    exp_t e;
    e.id = id;
    e.ct = ct;
    e.err = err;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_ready_onehot0", 128'($countones(req_ready) <= 1), 128'd1);
      chk("resp_valid_onehot0", 128'($countones(resp_valid) <= 1), 128'd1);
      chk("ready_in_idle_only", 128'(|req_ready && busy), 128'd0);
      if ((resp_valid & resp_ready) != 0) begin
        mid = -1;
        for (int k = 0; k < N; k++) if (resp_valid[k]) mid = k;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got id %0d want none", mid);
        end else begin
          me = exp_q.pop_front();
          chk("resp_id", 128'(mid), 128'(me.id));
          chk("resp_ct", resp_ciphertext, me.ct);
          chk("resp_err", 128'(resp_err), 128'(me.err));
        end
      end
    end
  end

  task automatic send(int i, logic [127:0] p, logic [127:0] k, output int acc);
    int n = 0;
    @(posedge clk);
    #1;
    req_plaintext[128*i +: 128] = p;
    req_key[128*i +: 128] = k;
    req_valid[i] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[i] && n < 400);
    if (!req_ready[i]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no req_ready[%0d] want accept", i);
    end
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_resp(int i, output int seen);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid[i] && n < 400);
    if (!resp_valid[i]) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got no resp_valid[%0d] want response", i);
    end
    seen = cyc;
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy) && n < 800);
    chk("drain_pending", 128'(exp_q.size()), 128'd0);
    chk("drain_idle", 128'(busy), 128'd0);
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_req_ready"}, 128'(req_ready), 128'd0);
    chk({tag, "_resp_valid"}, 128'(resp_valid), 128'd0);
    chk({tag, "_resp_ct"}, resp_ciphertext, 128'd0);
    chk({tag, "_resp_err"}, 128'(resp_err), 128'd0);
    chk({tag, "_core_start"}, 128'(core_start), 128'd0);
    chk({tag, "_core_pt"}, core_plaintext, 128'd0);
    chk({tag, "_core_key"}, core_key, 128'd0);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_grant_id"}, 128'(grant_id), 128'd0);
  endtask

  int a0, a1, a2, a3, seen;

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_plaintext = '0;
    req_key = '0;
    resp_ready = '1;
    repeat (3) @(posedge clk);
    #1;
    req_valid = '1;
    #1;
    chk_zero_outputs("reset");
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", 128'(busy), 128'd0);
    chk("post_reset_grant", 128'(grant_id), 128'd0);

    // Round robin: all four contend, requester 0 returns for a second turn.
    expect_resp(0, C_B, 1'b0);
    expect_resp(1, C_Z, 1'b0);
    expect_resp(2, C_F, 1'b0);
    expect_resp(3, C_X, 1'b0);
    expect_resp(0, C_Y, 1'b0);
    fork
      begin send(0, P_B, K_B, a0); send(0, P_Y, K_Y, a0); end
      send(1, '0, '0, a1);
      send(2, P_F, K_F, a2);
      send(3, P_X, K_X, a3);
    join
    wait_drain();

    // FIPS-197 vector on requester 2 with latency check.
    expect_resp(2, C_F, 1'b0);
    send(2, P_F, K_F, a2);
    wait_resp(2, seen);
    chk("fips_latency", 128'(seen - a2), 128'd12);
    chk("fips_grant", 128'(grant_id), 128'd2);
    wait_drain();

    // Backpressure on requester 1 with requester 3 waiting.
    resp_ready[1] = 1'b0;
    expect_resp(1, C_Z, 1'b0);
    send(1, '0, '0, a1);
    wait_resp(1, seen);
    expect_resp(3, C_X, 1'b0);
    fork
      send(3, P_X, K_X, a3);
    join_none
    repeat (20) begin
      @(negedge clk);
      chk("bp_resp_valid", 128'(resp_valid), 128'h2);
      chk("bp_ct", resp_ciphertext, C_Z);
      chk("bp_busy", 128'(busy), 128'd1);
      chk("bp_req_ready", 128'(req_ready), 128'd0);
    end
    @(posedge clk);
    #1;
    resp_ready[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_idle", 128'(busy), 128'd0);
    chk("bp_release_ready", 128'(req_ready), 128'h8);
    wait_drain();

    // Hung core: watchdog aborts, then a normal block follows.
    hang = 1'b1;
    expect_resp(0, 128'd0, 1'b1);
    send(0, P_F, K_F, a0);
    wait_resp(0, seen);
    chk("wd_latency", 128'(seen - a0), 128'(TO + 1));
    wait_drain();
    hang = 1'b0;
    expect_resp(1, C_B, 1'b0);
    send(1, P_B, K_B, a1);
    wait_drain();

    // Reset during WAIT discards the block; 0 then beats 3 afterwards.
    send(3, P_X, K_X, a3);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("wait_reset");
    expect_resp(0, C_F, 1'b0);
    expect_resp(3, C_B, 1'b0);
    fork
      send(0, P_F, K_F, a0);
      send(3, P_B, K_B, a3);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("rst_req_ready", 128'(req_ready), 128'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_first_ready", 128'(req_ready), 128'h1);
      end
    join
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
